// File: rtl/switch_allocator.sv
// Zero-cycle separable switch allocator: one round-robin arbiter per output port,
// held by the packet owner from head flit to tail flit (wormhole locking).
module switch_allocator #(
   parameter int NUM_INPORTS  = 5,
   parameter int NUM_OUTPORTS = 5,
   parameter int NUM_VCS      = 2,
   localparam int IW = (NUM_INPORTS  > 1) ? $clog2(NUM_INPORTS)  : 1,
   localparam int OW = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
   localparam int VW = (NUM_VCS      > 1) ? $clog2(NUM_VCS)      : 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_INPORTS-1:0]                 req_valid,
   input  logic [NUM_INPORTS-1:0][OW-1:0]         req_outport,
   input  logic [NUM_INPORTS-1:0][VW-1:0]         req_vc,
   input  logic [NUM_INPORTS-1:0]                 req_tail,
   input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   buffer_available,
   output logic [NUM_INPORTS-1:0]                 grant,
   output logic [NUM_OUTPORTS-1:0]                xbar_valid,
   output logic [NUM_OUTPORTS-1:0][IW-1:0]        xbar_sel,
   output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   packet_sent
);

   logic [NUM_OUTPORTS-1:0]                  locked_q, locked_d;
   logic [NUM_OUTPORTS-1:0][IW-1:0]          owner_q, owner_d;
   logic [NUM_OUTPORTS-1:0][IW-1:0]          ptr_q, ptr_d;

   logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0] elig;
   logic [NUM_OUTPORTS-1:0]                  win_valid;
   logic [NUM_OUTPORTS-1:0][IW-1:0]          win_idx;

   // Out-of-range outport or VC codes never match, so they can neither win nor move state.
   always_comb begin
      elig = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         for (int i = 0; i < NUM_INPORTS; i++) begin
            if (req_valid[i] && (req_outport[i] == OW'(o)) &&
                ({1'b0, req_vc[i]} < (VW+1)'(NUM_VCS))) begin
               elig[o][i] = buffer_available[o][req_vc[i]];
            end
         end
      end
   end

   // Scan from the far end back toward ptr so the candidate closest to ptr is written last.
   always_comb begin
      int idx;
      idx       = 0;
      win_valid = '0;
      win_idx   = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         if (locked_q[o]) begin
            win_idx[o]   = owner_q[o];
            win_valid[o] = elig[o][owner_q[o]];
         end else begin
            for (int k = NUM_INPORTS - 1; k >= 0; k--) begin
               idx = int'(ptr_q[o]) + k;
               if (idx >= NUM_INPORTS) idx = idx - NUM_INPORTS;
               if (elig[o][idx]) begin
                  win_valid[o] = 1'b1;
                  win_idx[o]   = IW'(idx);
               end
            end
         end
      end
   end

   always_comb begin
      grant       = '0;
      xbar_valid  = '0;
      xbar_sel    = '0;
      packet_sent = '0;
      if (!rst) begin
         for (int o = 0; o < NUM_OUTPORTS; o++) begin
            if (win_valid[o]) begin
               xbar_valid[o]                         = 1'b1;
               xbar_sel[o]                           = win_idx[o];
               grant[win_idx[o]]                     = 1'b1;
               packet_sent[o][req_vc[win_idx[o]]]    = 1'b1;
            end
         end
      end
   end

   // The pointer only advances past a winner once its whole packet has gone.
   always_comb begin
      locked_d = locked_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
         if (win_valid[o]) begin
            if (req_tail[win_idx[o]]) begin
               locked_d[o] = 1'b0;
               ptr_d[o]    = (int'(win_idx[o]) == NUM_INPORTS - 1) ? '0 : win_idx[o] + 1'b1;
            end else if (!locked_q[o]) begin
               locked_d[o] = 1'b1;
               owner_d[o]  = win_idx[o];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q <= '0;
         owner_q  <= '0;
         ptr_q    <= '0;
      end else begin
         locked_q <= locked_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: single-cycle vector table plus multi-cycle lock,
// credit and reset sequences, checked through an expected-result queue.
module tb_switch_allocator;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [4:0]           req_valid;
   logic [4:0][2:0]      req_outport;
   logic [4:0]           req_vc;
   logic [4:0]           req_tail;
   logic [4:0][1:0]      buffer_available;
   logic [4:0]           grant;
   logic [4:0]           xbar_valid;
   logic [4:0][2:0]      xbar_sel;
   logic [4:0][1:0]      packet_sent;

   always #5 clk = ~clk;

   switch_allocator #(
      .NUM_INPORTS (5),
      .NUM_OUTPORTS(5),
      .NUM_VCS     (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_outport     (req_outport),
      .req_vc          (req_vc),
      .req_tail        (req_tail),
      .buffer_available(buffer_available),
      .grant           (grant),
      .xbar_valid      (xbar_valid),
      .xbar_sel        (xbar_sel),
      .packet_sent     (packet_sent)
   );

   typedef struct packed {
      logic [4:0]      valid;
      logic [4:0][2:0] outp;
      logic [4:0]      vc;
      logic [4:0]      tail;
      logic [4:0][1:0] bav;
   } in_t;

   typedef struct packed {
      logic [4:0]      grant;
      logic [4:0]      xv;
      logic [4:0][2:0] xsel;
      logic [4:0][1:0] ps;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    errors = 0;
   int    checks = 0;

   function automatic in_t add_req(input in_t b, input int i, input int o, input int vc, input bit tail);
      b.valid[i] = 1'b1;
      b.outp[i]  = 3'(o);
      b.vc[i]    = 1'(vc);
      b.tail[i]  = tail;
      return b;
   endfunction

   function automatic exp_t add_gnt(input exp_t b, input int i, input int o, input int vc);
      b.grant[i] = 1'b1;
      b.xv[o]    = 1'b1;
      b.xsel[o]  = 3'(i);
      b.ps[o][vc] = 1'b1;
      return b;
   endfunction

   task automatic compare_outputs();
      exp_t  e;
      string nm;
      if (sb_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      $display("txn %0s: grant=%b xv=%b xsel=%h ps=%h (want %b %b %h %h)",
               nm, grant, xbar_valid, xbar_sel, packet_sent, e.grant, e.xv, e.xsel, e.ps);
      checks += 4;
      if (grant !== e.grant) begin
         errors++;
         $display("FAIL %0s.grant: got %b want %b", nm, grant, e.grant);
      end
      if (xbar_valid !== e.xv) begin
         errors++;
         $display("FAIL %0s.xbar_valid: got %b want %b", nm, xbar_valid, e.xv);
      end
      if (xbar_sel !== e.xsel) begin
         errors++;
         $display("FAIL %0s.xbar_sel: got %h want %h", nm, xbar_sel, e.xsel);
      end
      if (packet_sent !== e.ps) begin
         errors++;
         $display("FAIL %0s.packet_sent: got %h want %h", nm, packet_sent, e.ps);
      end
   endtask

   task automatic apply(input logic r, input in_t s, input exp_t e, input string nm);
      @(posedge clk);
      #1;
      rst              = r;
      req_valid        = s.valid;
      req_outport      = s.outp;
      req_vc           = s.vc;
      req_tail         = s.tail;
      buffer_available = s.bav;
      sb_q.push_back(e);
      nm_q.push_back(nm);
      @(negedge clk);
      compare_outputs();
   endtask

   vec_t  tbl[8];
   string tbl_nm[8];
   in_t   z, s, s2;
   exp_t  n;

   initial begin
      rst              = 1'b1;
      req_valid        = '0;
      req_outport      = '0;
      req_vc           = '0;
      req_tail         = '0;
      buffer_available = '0;
      z     = '0;
      z.bav = '1;
      n     = '0;

      tbl[0].i = z;                                   tbl[0].e = n;
      tbl_nm[0] = "idle";
      s = add_req(z, 4, 2, 1, 1'b1); s.bav[2][1] = 1'b0;
      tbl[1].i = s;                                   tbl[1].e = n;
      tbl_nm[1] = "no_credit";
      tbl[2].i = add_req(z, 4, 2, 1, 1'b1);           tbl[2].e = add_gnt(n, 4, 2, 1);
      tbl_nm[2] = "credit_ok";
      tbl[3].i = add_req(add_req(add_req(z, 0, 0, 0, 1'b1), 1, 1, 0, 1'b1), 2, 2, 0, 1'b1);
      tbl[3].e = add_gnt(add_gnt(add_gnt(n, 0, 0, 0), 1, 1, 0), 2, 2, 0);
      tbl_nm[3] = "parallel";
      tbl[4].i = add_req(z, 3, 7, 0, 1'b1);           tbl[4].e = n;
      tbl_nm[4] = "bad_outport";
      tbl[5].i = add_req(add_req(z, 1, 4, 1, 1'b1), 3, 4, 1, 1'b1);
      tbl[5].e = add_gnt(n, 1, 4, 1);
      tbl_nm[5] = "rr_from_zero";
      tbl[6].i = add_req(add_req(z, 0, 1, 0, 1'b1), 2, 1, 0, 1'b1);
      tbl[6].e = add_gnt(n, 0, 1, 0);
      tbl_nm[6] = "first_of_two";
      s = add_req(add_req(z, 2, 0, 0, 1'b1), 3, 0, 1, 1'b1); s.bav[0][0] = 1'b0;
      tbl[7].i = s;                                   tbl[7].e = add_gnt(n, 3, 0, 1);
      tbl_nm[7] = "skip_no_credit";

      // Each vector starts from reset; the reset cycle itself must mask active requests.
      for (int k = 0; k < 8; k++) begin
         apply(1'b1, tbl[k].i, n, "in_reset");
         apply(1'b0, tbl[k].i, tbl[k].e, tbl_nm[k]);
      end

      // Round-robin pointer moves past the single-flit winner.
      apply(1'b1, z, n, "rst");
      s = add_req(add_req(z, 0, 1, 0, 1'b1), 2, 1, 0, 1'b1);
      apply(1'b0, s, add_gnt(n, 0, 1, 0), "rr_c1");
      apply(1'b0, s, add_gnt(n, 2, 1, 0), "rr_c2");

      // Three-flit packet from input 3 holds outport 0 against input 1.
      apply(1'b1, z, n, "rst");
      apply(1'b0, add_req(z, 2, 0, 0, 1'b1), add_gnt(n, 2, 0, 0), "pkt_setup");
      s  = add_req(add_req(z, 3, 0, 1, 1'b0), 1, 0, 0, 1'b1);
      s2 = add_req(add_req(z, 3, 0, 1, 1'b1), 1, 0, 0, 1'b1);
      apply(1'b0, s,  add_gnt(n, 3, 0, 1), "pkt_head");
      apply(1'b0, s,  add_gnt(n, 3, 0, 1), "pkt_body");
      apply(1'b0, s2, add_gnt(n, 3, 0, 1), "pkt_tail");
      apply(1'b0, add_req(z, 1, 0, 0, 1'b1), add_gnt(n, 1, 0, 0), "pkt_after");

      // Owner idles while locked; ptr stays 0 through non-tail grants, becomes 3 on tail.
      apply(1'b1, z, n, "rst");
      apply(1'b0, add_req(z, 2, 3, 0, 1'b0), add_gnt(n, 2, 3, 0), "idle_head");
      apply(1'b0, add_req(z, 0, 3, 0, 1'b1), n, "idle_gap1");
      apply(1'b0, add_req(z, 0, 3, 0, 1'b1), n, "idle_gap2");
      apply(1'b0, add_req(add_req(z, 2, 3, 0, 1'b0), 0, 3, 0, 1'b1), add_gnt(n, 2, 3, 0), "idle_body");
      apply(1'b0, add_req(add_req(z, 2, 3, 0, 1'b1), 0, 3, 0, 1'b1), add_gnt(n, 2, 3, 0), "idle_tail");
      apply(1'b0, add_req(add_req(z, 0, 3, 0, 1'b1), 4, 3, 0, 1'b1), add_gnt(n, 4, 3, 0), "ptr_after");
      apply(1'b0, add_req(z, 0, 3, 0, 1'b1), add_gnt(n, 0, 3, 0), "late_in0");

      // Owner loses credit mid-packet: lock held, others denied, resumes on credit return.
      apply(1'b1, z, n, "rst");
      apply(1'b0, add_req(z, 4, 2, 1, 1'b0), add_gnt(n, 4, 2, 1), "cr_head");
      s = add_req(add_req(z, 4, 2, 1, 1'b0), 0, 2, 0, 1'b1); s.bav[2][1] = 1'b0;
      apply(1'b0, s, n, "cr_lost");
      apply(1'b0, add_req(add_req(z, 4, 2, 1, 1'b1), 0, 2, 0, 1'b1), add_gnt(n, 4, 2, 1), "cr_back");
      apply(1'b0, add_req(z, 0, 2, 0, 1'b1), add_gnt(n, 0, 2, 0), "cr_other");

      // Reset mid-packet releases the lock and restarts arbitration at ptr 0.
      apply(1'b1, z, n, "rst");
      apply(1'b0, add_req(z, 3, 1, 0, 1'b0), add_gnt(n, 3, 1, 0), "mr_head");
      s = add_req(add_req(z, 3, 1, 0, 1'b0), 0, 1, 0, 1'b1);
      apply(1'b1, s, n, "mr_reset");
      apply(1'b0, add_req(add_req(z, 3, 1, 0, 1'b0), 1, 1, 0, 1'b1), add_gnt(n, 1, 1, 0), "mr_after");

      if (sb_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
